// File: rtl/mono_note_stack.sv
// mono_note_stack
//   Last-note-priority key tracker. Holds up to DEPTH pressed keys in press
//   order and presents the newest one to the voice path. Releasing the top
//   key falls back to the previously held key. The gate drops only when no
//   key is held.
//
//   Every strobe is first captured in a one-entry pending latch. The FSM
//   then takes the event through MATCH (parallel key compare) and APPLY
//   (stack update). Outputs change three edges after the strobe.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   note_on    one-cycle Note On strobe
//   note_off   one-cycle Note Off strobe
//   note       key number qualifying the strobe
//   velocity   velocity qualifying the strobe (0 on note_on means release)
//   gate       high while at least one key is held
//   last_note  key of the top-of-stack entry
//   last_vel   velocity of the top-of-stack entry
//   retrig     one-cycle pulse when a new key becomes top
//   count      number of held keys (0..DEPTH)
//   busy       event in progress
//   err        sticky, an event was lost (overrun or simultaneous strobes)
//
// States
//   IDLE  | waiting for an event in the pending latch
//   MATCH | compare the event key against all held keys
//   APPLY | update stack, count and outputs

module mono_note_stack #(
    parameter int DEPTH              = 8,
    parameter bit RETRIG_ON_FALLBACK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_on,
    input  logic       note_off,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    output logic       gate,
    output logic [6:0] last_note,
    output logic [6:0] last_vel,
    output logic       retrig,
    output logic [4:0] count,
    output logic       busy,
    output logic       err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [6:0]    stk_note [DEPTH];
    logic [6:0]    stk_vel  [DEPTH];
    logic [6:0]    nxt_note [DEPTH];
    logic [6:0]    nxt_vel  [DEPTH];

    logic          pend_valid;
    logic          pend_rel;
    logic [6:0]    pend_note;
    logic [6:0]    pend_vel;

    logic          ev_rel;
    logic [6:0]    ev_note;
    logic [6:0]    ev_vel;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          m_hit;
    logic [IW-1:0] m_idx;

    logic          take_pend;
    logic          any_strobe;
    logic          in_rel;

    logic          a_remove;
    logic          a_push;
    logic [IW-1:0] a_r;
    logic [4:0]    a_cnt;
    logic [IW-1:0] a_top;
    logic          a_was_top;

    assign any_strobe = note_on | note_off;
    // A simultaneous on/off pair is treated as a release.
    assign in_rel     = note_off | (note_on & (velocity == 7'd0));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_pend = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_valid) begin
                    take_pend = 1'b1;
                    state_nxt = MATCH;
                end
            end
            MATCH: begin
                state_nxt = APPLY;
            end
            APPLY: begin
                // Back-to-back service: skip IDLE entirely.
                if (pend_valid) begin
                    take_pend = 1'b1;
                    state_nxt = MATCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lowest matching index wins; the loop runs top-down so the last
    // assignment is the bottom-most hit.
    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((5'(i) < count) && (stk_note[i] == ev_note)) begin
                m_hit = 1'b1;
                m_idx = IW'(i);
            end
        end
    end

    // Stack update: optionally remove one entry (shift everything above it
    // down), then optionally write the event at the new top.
    always_comb begin
        a_remove = 1'b0;
        a_push   = 1'b0;
        a_r      = '0;
        a_cnt    = count;
        if (!ev_rel) begin
            a_push = 1'b1;
            if (hit) begin
                a_remove = 1'b1;
                a_r      = hit_idx;
            end else if (count == 5'(DEPTH)) begin
                a_remove = 1'b1;
                a_r      = '0;
            end else begin
                a_cnt = count + 5'd1;
            end
        end else if (hit) begin
            a_remove = 1'b1;
            a_r      = hit_idx;
            a_cnt    = count - 5'd1;
        end
        a_top     = IW'(a_cnt - 5'd1);
        a_was_top = hit && (hit_idx == IW'(count - 5'd1));

        for (int i = 0; i < DEPTH; i++) begin
            nxt_note[i] = stk_note[i];
            nxt_vel[i]  = stk_vel[i];
        end
        if (a_remove) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= a_r) begin
                    nxt_note[i] = stk_note[i+1];
                    nxt_vel[i]  = stk_vel[i+1];
                end
            end
        end
        if (a_push) begin
            nxt_note[a_top] = ev_note;
            nxt_vel[a_top]  = ev_vel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_note[i] <= '0;
                stk_vel[i]  <= '0;
            end
            pend_valid <= 1'b0;
            pend_rel   <= 1'b0;
            pend_note  <= '0;
            pend_vel   <= '0;
            ev_rel     <= 1'b0;
            ev_note    <= '0;
            ev_vel     <= '0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            gate       <= 1'b0;
            last_note  <= '0;
            last_vel   <= '0;
            retrig     <= 1'b0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            retrig <= 1'b0;

            if (take_pend) begin
                pend_valid <= 1'b0;
                ev_rel     <= pend_rel;
                ev_note    <= pend_note;
                ev_vel     <= pend_vel;
            end
            // The latch frees up on the same edge it is consumed, so a new
            // strobe may refill it then.
            if (any_strobe) begin
                if (!pend_valid || take_pend) begin
                    pend_valid <= 1'b1;
                    pend_rel   <= in_rel;
                    pend_note  <= note;
                    pend_vel   <= velocity;
                end else begin
                    err <= 1'b1;
                end
                if (note_on && note_off) begin
                    err <= 1'b1;
                end
            end

            if (state == MATCH) begin
                hit     <= m_hit;
                hit_idx <= m_idx;
            end

            if (state == APPLY) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stk_note[i] <= nxt_note[i];
                    stk_vel[i]  <= nxt_vel[i];
                end
                count <= a_cnt;
                gate  <= (a_cnt != 5'd0);
                if (a_push) begin
                    last_note <= ev_note;
                    last_vel  <= ev_vel;
                    retrig    <= 1'b1;
                end else if (a_was_top && (a_cnt != 5'd0)) begin
                    // Fallback to the key underneath; on empty the last
                    // pitch is held for the release phase.
                    last_note <= nxt_note[a_top];
                    last_vel  <= nxt_vel[a_top];
                    retrig    <= RETRIG_ON_FALLBACK;
                end
            end
        end
    end

endmodule

// File: tb/tb_mono_note_stack.sv
// tb_mono_note_stack
//   Directed and randomized checks of mono_note_stack against a queue-based
//   reference model of the held-key list.

module tb_mono_note_stack;

    localparam int DEPTH  = 8;
    localparam bit RETRIG = 1'b0;

    logic       clk;
    logic       rst;
    logic       note_on;
    logic       note_off;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       gate;
    logic [6:0] last_note;
    logic [6:0] last_vel;
    logic       retrig;
    logic [4:0] count;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] n;
        logic [6:0] v;
    } key_t;

    key_t q[$];
    int   m_last_note;
    int   m_last_vel;
    bit   m_err;

    mono_note_stack #(
        .DEPTH(DEPTH),
        .RETRIG_ON_FALLBACK(RETRIG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .note_on(note_on),
        .note_off(note_off),
        .note(note),
        .velocity(velocity),
        .gate(gate),
        .last_note(last_note),
        .last_vel(last_vel),
        .retrig(retrig),
        .count(count),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_note = 0;
        m_last_vel  = 0;
        m_err       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        note_on  = 1'b0;
        note_off = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_outputs(input string tag, input bit exp_retrig, input bit exp_busy);
        chk({tag, ".gate"},   8'(gate),      8'(q.size() > 0));
        chk({tag, ".note"},   8'(last_note), 8'(m_last_note));
        chk({tag, ".vel"},    8'(last_vel),  8'(m_last_vel));
        chk({tag, ".count"},  8'(count),     8'(q.size()));
        chk({tag, ".retrig"}, 8'(retrig),    8'(exp_retrig));
        chk({tag, ".busy"},   8'(busy),      8'(exp_busy));
        chk({tag, ".err"},    8'(err),       8'(m_err));
    endtask

    // Model of one event from the list-of-held-keys point of view.
    task automatic model_event(input bit on, input bit off, input int n, input int v,
                               output bit exp_retrig);
        bit is_rel;
        int idx;
        bit was_top;
        exp_retrig = 1'b0;
        is_rel = off || (on && v == 0);
        if (on && off) m_err = 1'b1;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (int'(q[i].n) == n) idx = i;
        end
        if (!is_rel) begin
            if (idx >= 0) q.delete(idx);
            else if (q.size() == DEPTH) q.delete(0);
            q.push_back(key_t'{n: 7'(n), v: 7'(v)});
            m_last_note = n;
            m_last_vel  = v;
            exp_retrig  = 1'b1;
        end else if (idx >= 0) begin
            was_top = (idx == q.size() - 1);
            q.delete(idx);
            if (was_top && q.size() > 0) begin
                m_last_note = int'(q[q.size()-1].n);
                m_last_vel  = int'(q[q.size()-1].v);
                exp_retrig  = RETRIG;
            end
        end
    endtask

    // Starts and ends just after a falling edge. Strobe sampled at edge 0,
    // result expected after edge 3, retrig gone after edge 4.
    task automatic send(input string tag, input bit on, input bit off, input int n, input int v);
        bit er;
        note_on  = on;
        note_off = off;
        note     = 7'(n);
        velocity = 7'(v);
        @(posedge clk);
        @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b0;
        chk({tag, ".c0busy"}, 8'(busy), 8'd0);
        @(negedge clk);
        chk({tag, ".c1busy"}, 8'(busy), 8'd1);
        chk({tag, ".c1hold"}, 8'(count), 8'(q.size()));
        @(negedge clk);
        chk({tag, ".c2busy"}, 8'(busy), 8'd1);
        chk({tag, ".c2hold"}, 8'(last_note), 8'(m_last_note));
        model_event(on, off, n, v, er);
        @(negedge clk);
        chk_outputs({tag, ".c3"}, er, 1'b0);
        @(negedge clk);
        chk({tag, ".c4retrig"}, 8'(retrig), 8'd0);
    endtask

    initial begin
        bit er;
        rst      = 1'b0;
        note_on  = 1'b0;
        note_off = 1'b0;
        note     = '0;
        velocity = '0;
        model_reset();

        // Reset state, with a strobe in the reset cycle that must be ignored.
        @(negedge clk);
        rst     = 1'b1;
        note_on = 1'b1;
        note    = 7'd33;
        velocity = 7'd50;
        @(posedge clk);
        @(negedge clk);
        note_on = 1'b0;
        rst     = 1'b0;
        chk_outputs("reset", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_outputs("reset_ignore", 1'b0, 1'b0);

        // First press.
        send("p60", 1, 0, 60, 100);
        chk("p60.note", 8'(last_note), 8'd60);
        chk("p60.vel", 8'(last_vel), 8'd100);

        // Legato fallback chain.
        do_reset();
        send("a60", 1, 0, 60, 90);
        send("a64", 1, 0, 64, 91);
        send("a67", 1, 0, 67, 92);
        send("r67", 0, 1, 67, 0);
        chk("r67.note", 8'(last_note), 8'd64);
        chk("r67.count", 8'(count), 8'd2);
        send("r64", 0, 1, 64, 0);
        chk("r64.note", 8'(last_note), 8'd60);
        send("r60", 0, 1, 60, 0);
        chk("r60.gate", 8'(gate), 8'd0);
        chk("r60.hold", 8'(last_note), 8'd60);

        // Non-top release, then release via note_on with velocity 0.
        do_reset();
        send("b60", 1, 0, 60, 80);
        send("b64", 1, 0, 64, 81);
        send("bnt60", 0, 1, 60, 0);
        chk("bnt60.note", 8'(last_note), 8'd64);
        chk("bnt60.count", 8'(count), 8'd1);
        send("bv0_64", 1, 0, 64, 0);
        chk("bv0_64.count", 8'(count), 8'd0);

        // Overflow drops the oldest key.
        do_reset();
        for (int k = 40; k <= 48; k++) send("fill", 1, 0, k, k + 10);
        chk("fill.count", 8'(count), 8'd8);
        chk("fill.note", 8'(last_note), 8'd48);
        send("rel40miss", 0, 1, 40, 0);
        chk("rel40miss.count", 8'(count), 8'd8);
        send("rel48", 0, 1, 48, 0);
        chk("rel48.note", 8'(last_note), 8'd47);

        // Pending latch: second strobe one cycle later, third one overruns.
        do_reset();
        note_on  = 1'b1;
        note     = 7'd60;
        velocity = 7'd100;
        @(posedge clk);
        @(negedge clk);
        velocity = 7'd20;
        @(posedge clk);
        @(negedge clk);
        note     = 7'd70;
        velocity = 7'd50;
        @(posedge clk);
        @(negedge clk);
        note_on = 1'b0;
        model_event(1, 0, 60, 100, er);
        chk("pend.err", 8'(err), 8'd1);
        chk("pend.busy2", 8'(busy), 8'd1);
        m_err = 1'b1;
        @(negedge clk);
        chk_outputs("pend.first", 1'b1, 1'b1);
        @(negedge clk);
        chk("pend.busy4", 8'(busy), 8'd1);
        chk("pend.retrig4", 8'(retrig), 8'd0);
        model_event(1, 0, 60, 20, er);
        @(negedge clk);
        chk_outputs("pend.second", 1'b1, 1'b0);
        chk("pend.vel20", 8'(last_vel), 8'd20);
        repeat (3) @(negedge clk);
        chk_outputs("pend.nodrop", 1'b0, 1'b0);

        // Simultaneous on/off: release wins, err set.
        do_reset();
        send("s60", 1, 0, 60, 70);
        send("clash", 1, 1, 60, 30);
        chk("clash.count", 8'(count), 8'd0);
        chk("clash.err", 8'(err), 8'd1);

        // Reset during MATCH.
        do_reset();
        send("m60", 1, 0, 60, 70);
        note_on  = 1'b1;
        note     = 7'd72;
        velocity = 7'd90;
        @(posedge clk);
        @(negedge clk);
        note_on = 1'b0;
        @(negedge clk);
        chk("mrst.inmatch", 8'(busy), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_outputs("mrst", 1'b0, 1'b0);
        send("mrst.rel60", 0, 1, 60, 0);

        // Randomized events over a small key range so hits and overflow occur.
        do_reset();
        for (int t = 0; t < 300; t++) begin
            int kind;
            int n;
            int v;
            kind = int'($urandom_range(0, 3));
            n    = 50 + int'($urandom_range(0, 11));
            v    = int'($urandom_range(1, 127));
            case (kind)
                0, 1: send("rnd.press", 1, 0, n, v);
                2:    send("rnd.off", 0, 1, n, v);
                default: send("rnd.on0", 1, 0, n, 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
